// File: rtl/murmur_bloom_filter_if.sv
// Handshake bundle for murmur_bloom_filter: word input, result output, clear and status.
// A transfer happens on any clock edge where valid & ready are both high; the sender holds its payload stable until then.
interface murmur_bloom_filter_if #(
  parameter int WORD_BITS   = 256,
  parameter int FILTER_BITS = 256
);
  localparam int IW = $clog2(FILTER_BITS);

  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_BITS-1:0] in_word;
  logic                 in_insert;
  logic                 clear;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_present;
  logic [31:0]          out_hash;
  logic                 busy;
  logic [IW:0]          fill_count;
  logic [2:0]           dbg_state;

  modport slave (
    input  in_valid, in_word, in_insert, clear, out_ready,
    output in_ready, out_valid, out_present, out_hash, busy, fill_count, dbg_state
  );

  modport master (
    output in_valid, in_word, in_insert, clear, out_ready,
    input  in_ready, out_valid, out_present, out_hash, busy, fill_count, dbg_state
  );
endinterface

// File: rtl/murmur_bloom_filter.sv
// Bloom-filter membership engine hashing each word with NUM_HASHES seeded MurmurHash3-32 block chains.
// Define MURMUR_BLOOM_FMIX_EN to add the one-cycle MurmurHash3 finaliser (FINAL state) before indexing.
module murmur_bloom_filter #(
  parameter int          WORD_BITS   = 256,
  parameter int          FILTER_BITS = 256,
  parameter int          NUM_HASHES  = 2,
  parameter logic [31:0] SEED0       = 32'hF00DBAAD
) (
  input  logic                clock,
  input  logic                reset,
  murmur_bloom_filter_if.slave bus
);
  localparam int NB   = WORD_BITS / 32;
  localparam int IW   = $clog2(FILTER_BITS);
  localparam int CW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int NCLR = FILTER_BITS / 32;
  localparam int KW   = $clog2(NCLR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HASH   = 3'd1,
    S_FINAL  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4,
    S_CLEAR  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_chunk;
  logic [KW-1:0]        r_clr_idx;
  logic [WORD_BITS-1:0] r_word;
  logic                 r_insert;
  logic [31:0]          r_h [NUM_HASHES];
  logic [FILTER_BITS-1:0] r_filter;
  logic [IW:0]          r_fill;
  logic                 r_present;
  logic [31:0]          r_hash;
  logic                 r_clr_pend;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_last_chunk;
  logic                 w_last_clr;
  logic [31:0]          w_chunk;
  logic [IW-1:0]        w_idx [NUM_HASHES];
  logic                 w_present;
  logic [FILTER_BITS-1:0] w_set;
  logic [2:0]           w_add;

  function automatic logic [31:0] seed_of(input int j);
    return SEED0 + 32'(j) * 32'h9E3779B9;
  endfunction

  function automatic logic [31:0] mm_block(input logic [31:0] h_in, input logic [31:0] c);
    logic [31:0] k;
    logic [31:0] h;
    k = c * 32'hcc9e2d51;
    k = {k[16:0], k[31:17]};
    k = k * 32'h1b873593;
    h = h_in ^ k;
    h = {h[18:0], h[31:19]};
    return h * 32'd5 + 32'he6546b64;
  endfunction

`ifdef MURMUR_BLOOM_FMIX_EN
  function automatic logic [31:0] mm_fmix(input logic [31:0] h_in);
    logic [31:0] h;
    h = h_in ^ 32'(WORD_BITS / 8);
    h = h ^ (h >> 16);
    h = h * 32'h85ebca6b;
    h = h ^ (h >> 13);
    h = h * 32'hc2b2ae35;
    return h ^ (h >> 16);
  endfunction
`endif

  // Reset is also an input-side gate so nothing can be accepted while it is held.
  assign w_in_ready   = reset && (r_state == S_IDLE) && !bus.clear && !r_clr_pend;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_last_chunk = (r_chunk == CW'(NB - 1));
  assign w_last_clr   = (r_clr_idx == KW'(NCLR - 1));

  always_comb begin
    w_chunk = '0;
    for (int i = 0; i < NB; i++) begin
      if (r_chunk == CW'(i)) w_chunk = r_word[32*i +: 32];
    end
  end

  // w_set accumulates the probed bits so a repeated index is only counted once.
  always_comb begin
    w_present = 1'b1;
    w_set     = '0;
    w_add     = '0;
    for (int j = 0; j < NUM_HASHES; j++) begin
      w_idx[j]  = r_h[j][IW-1:0];
      w_present = w_present & r_filter[w_idx[j]];
      if (!r_filter[w_idx[j]] && !w_set[w_idx[j]]) w_add = w_add + 3'd1;
      w_set[w_idx[j]] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.clear || r_clr_pend) w_next = S_CLEAR;
        else if (w_accept)           w_next = S_HASH;
      end
      S_HASH: begin
`ifdef MURMUR_BLOOM_FMIX_EN
        if (w_last_chunk) w_next = S_FINAL;
`else
        if (w_last_chunk) w_next = S_UPDATE;
`endif
      end
      S_FINAL:  w_next = S_UPDATE;
      S_UPDATE: w_next = S_DONE;
      S_DONE: begin
        if (bus.out_ready) w_next = (r_clr_pend || bus.clear) ? S_CLEAR : S_IDLE;
      end
      S_CLEAR: begin
        if (w_last_clr) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_clr_pend <= 1'b0;
    end else if (w_next == S_CLEAR && r_state != S_CLEAR) begin
      r_clr_pend <= 1'b0;
    end else if (bus.clear && r_state != S_IDLE && r_state != S_CLEAR) begin
      r_clr_pend <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_chunk   <= '0;
      r_clr_idx <= '0;
      r_word    <= '0;
      r_insert  <= 1'b0;
      r_filter  <= '0;
      r_fill    <= '0;
      r_present <= 1'b0;
      r_hash    <= '0;
      for (int j = 0; j < NUM_HASHES; j++) r_h[j] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && !r_clr_pend) begin
            r_word   <= bus.in_word;
            r_insert <= bus.in_insert;
            r_chunk  <= '0;
            for (int j = 0; j < NUM_HASHES; j++) r_h[j] <= seed_of(j);
          end
        end
        S_HASH: begin
          for (int j = 0; j < NUM_HASHES; j++) r_h[j] <= mm_block(r_h[j], w_chunk);
          r_chunk <= w_last_chunk ? '0 : r_chunk + CW'(1);
        end
`ifdef MURMUR_BLOOM_FMIX_EN
        S_FINAL: begin
          for (int j = 0; j < NUM_HASHES; j++) r_h[j] <= mm_fmix(r_h[j]);
        end
`endif
        S_UPDATE: begin
          r_present <= w_present;
          r_hash    <= r_h[0];
          if (r_insert) begin
            r_filter <= r_filter | w_set;
            r_fill   <= r_fill + (IW+1)'(w_add);
          end
        end
        S_CLEAR: begin
          for (int i = 0; i < NCLR; i++) begin
            if (r_clr_idx == KW'(i)) r_filter[32*i +: 32] <= '0;
          end
          if (w_last_clr) begin
            r_clr_idx <= '0;
            r_fill    <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.out_present = r_present;
  assign bus.out_hash    = r_hash;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.fill_count  = r_fill;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_murmur_bloom_filter.sv
// Scoreboard bench for murmur_bloom_filter: a set-of-bits reference model predicts each result,
// a monitor pops the expected queue whenever a result is handed over.
module tb_murmur_bloom_filter;
  localparam int WORD_BITS   = 64;
  localparam int FILTER_BITS = 256;
  localparam int NUM_HASHES  = 2;
  localparam int NB          = WORD_BITS / 32;
  localparam int IW          = $clog2(FILTER_BITS);
  localparam int EW          = IW + 1 + 1 + 32;
  localparam logic [31:0] SEED0 = 32'hF00DBAAD;
`ifdef MURMUR_BLOOM_FMIX_EN
  localparam int LAT = NB + 3;
`else
  localparam int LAT = NB + 2;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;

  murmur_bloom_filter_if #(.WORD_BITS(WORD_BITS), .FILTER_BITS(FILTER_BITS)) m_if ();

  murmur_bloom_filter #(
    .WORD_BITS(WORD_BITS), .FILTER_BITS(FILTER_BITS), .NUM_HASHES(NUM_HASHES), .SEED0(SEED0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (m_if)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit manual = 1'b0;
  bit prev_valid = 1'b0;
  logic [EW-1:0] exp_q[$];
  int lat_q[$];
  bit model_f [FILTER_BITS];
  int model_fill = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference hash: straight MurmurHash3-32 over the word's 32-bit chunks, lowest chunk first.
  function automatic logic [31:0] ref_hash(input logic [63:0] w, input int j);
    logic [31:0] h, k, c;
    h = SEED0 + 32'(j) * 32'h9E3779B9;
    for (int i = 0; i < NB; i++) begin
      c = w[32*i +: 32];
      k = c * 32'hcc9e2d51;
      k = (k << 15) | (k >> 17);
      k = k * 32'h1b873593;
      h = h ^ k;
      h = (h << 13) | (h >> 19);
      h = h * 32'd5 + 32'he6546b64;
    end
`ifdef MURMUR_BLOOM_FMIX_EN
    h = h ^ 32'(WORD_BITS / 8);
    h = h ^ (h >> 16);
    h = h * 32'h85ebca6b;
    h = h ^ (h >> 13);
    h = h * 32'hc2b2ae35;
    h = h ^ (h >> 16);
`endif
    return h;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < FILTER_BITS; i++) model_f[i] = 1'b0;
    model_fill = 0;
  endtask

  task automatic model_op(input logic [63:0] w, input bit ins);
    logic [31:0] h [NUM_HASHES];
    bit present;
    int idx;
    present = 1'b1;
    for (int j = 0; j < NUM_HASHES; j++) begin
      h[j] = ref_hash(w, j);
      present = present & model_f[h[j] % FILTER_BITS];
    end
    if (ins) begin
      for (int j = 0; j < NUM_HASHES; j++) begin
        idx = int'(h[j] % FILTER_BITS);
        if (!model_f[idx]) begin
          model_f[idx] = 1'b1;
          model_fill++;
        end
      end
    end
    exp_q.push_back({(IW+1)'(model_fill), present, h[0]});
  endtask

  always @(negedge clock) begin
    if (!manual) m_if.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency on each rising out_valid, payload on each result handshake.
  always @(negedge clock) begin
    logic [EW-1:0] e;
    #1;
    if (m_if.out_valid && !prev_valid) begin
      if (lat_q.size() == 0) check("lat_unexpected_valid", 1, 0);
      else check("latency", 64'(cyc - lat_q.pop_front()), 64'(LAT));
    end
    prev_valid = m_if.out_valid;
    if (m_if.out_valid && m_if.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_hash", 64'(m_if.out_hash), 64'(e[31:0]));
        check("out_present", 64'(m_if.out_present), 64'(e[32]));
        check("fill_count", 64'(m_if.fill_count), 64'(e[EW-1:33]));
      end
    end
  end

  task automatic send(input logic [63:0] w, input bit ins);
    int n = 0;
    @(negedge clock);
    m_if.in_valid  = 1'b1;
    m_if.in_word   = w;
    m_if.in_insert = ins;
    #1;
    while (!m_if.in_ready && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!m_if.in_ready) begin
      check("send_timeout", 1, 0);
    end else begin
      lat_q.push_back(cyc);
      model_op(w, ins);
    end
    @(negedge clock);
    m_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_if.busy) && n < 1000) begin
      @(negedge clock);
      #2;
      n++;
    end
    if (n >= 1000) check("drain_timeout", 1, 0);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!m_if.out_valid && n < 100) begin
      @(negedge clock);
      #2;
      n++;
    end
    if (!m_if.out_valid) check("out_valid_timeout", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    logic [63:0] pool [6];
    logic [31:0] held_hash;
    logic        held_present;
    int          n;

    m_if.in_valid  = 1'b0;
    m_if.in_word   = '0;
    m_if.in_insert = 1'b0;
    m_if.clear     = 1'b0;
    model_clear();
    for (int i = 0; i < 6; i++) pool[i] = {$urandom(), $urandom()};

    repeat (3) @(negedge clock);
    #1;
    check("reset_in_ready", 64'(m_if.in_ready), 0);
    check("reset_out_valid", 64'(m_if.out_valid), 0);
    check("reset_fill", 64'(m_if.fill_count), 0);
    check("reset_busy", 64'(m_if.busy), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("post_reset_in_ready", 64'(m_if.in_ready), 1);

    send(64'hDEADBEEF00000000, 1'b0);
    drain();
    check("query_fill_zero", 64'(m_if.fill_count), 0);
    send(64'hDEADBEEF00000000, 1'b0);
    drain();

    send(64'h0123456789ABCDEF, 1'b1);
    drain();
    check("first_insert_fill_1or2", 64'(m_if.fill_count == 1 || m_if.fill_count == 2), 1);
    send(64'h0123456789ABCDEF, 1'b1);
    drain();

    // Hold the result in DONE and watch it stay put.
    manual = 1'b1;
    @(negedge clock);
    m_if.out_ready = 1'b0;
    send({$urandom(), $urandom()}, 1'b1);
    wait_out_valid();
    held_hash    = m_if.out_hash;
    held_present = m_if.out_present;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #2;
      check("hold_valid", 64'(m_if.out_valid), 1);
      check("hold_stable", 64'({m_if.out_present, m_if.out_hash} == {held_present, held_hash}), 1);
      check("hold_in_ready", 64'(m_if.in_ready), 0);
    end
    @(negedge clock);
    m_if.out_ready = 1'b1;
    @(negedge clock);
    m_if.out_ready = 1'b0;
    #2;
    check("hold_back_idle", 64'(m_if.busy), 0);

    // Clear pulsed mid-hash: result first, then the full sweep.
    w = {$urandom(), $urandom()};
    send(w, 1'b1);
    m_if.clear = 1'b1;
    @(negedge clock);
    m_if.clear = 1'b0;
    wait_out_valid();
    @(negedge clock);
    m_if.out_ready = 1'b1;
    @(negedge clock);
    m_if.out_ready = 1'b0;
    model_clear();
    #2;
    n = 0;
    while (m_if.busy && n < 50) begin
      n++;
      @(negedge clock);
      #2;
    end
    check("clear_busy_cycles", 64'(n), 64'(FILTER_BITS / 32));
    check("clear_fill_zero", 64'(m_if.fill_count), 0);
    manual = 1'b0;
    send(w, 1'b1);
    drain();

    for (int t = 0; t < 40; t++) begin
      w = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 5)] : {$urandom(), $urandom()};
      send(w, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) begin
        drain();
        @(negedge clock);
        m_if.clear = 1'b1;
        model_clear();
        @(negedge clock);
        m_if.clear = 1'b0;
      end
    end
    drain();

    // Reset while hashing aborts the word with no result.
    send(64'h0123456789ABCDEF, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_out_valid", 64'(m_if.out_valid), 0);
    check("abort_fill", 64'(m_if.fill_count), 0);
    check("abort_busy", 64'(m_if.busy), 0);
    exp_q.delete();
    lat_q.delete();
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    send(64'h0123456789ABCDEF, 1'b1);
    drain();

    repeat (3) @(negedge clock);
    check("final_queue_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
